// File: rtl/uart_flash_cmd_pkg.sv
// Shared types and helpers for the ASCII flash-read command front-end.
//   state_t      : command FSM states
//   CMD_READ_*   : read command letters ('R' / 'r')
//   CHR_*        : line terminators and abort byte
//   hex_nibble() : ASCII hex digit -> {valid, nibble}
package flash_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LEN,
        ST_EOL,
        ST_RD,
        ST_WAIT,
        ST_SEND
    } state_t;

    localparam logic [7:0] CMD_READ_UC = 8'h52;
    localparam logic [7:0] CMD_READ_LC = 8'h72;
    localparam logic [7:0] CHR_CR      = 8'h0D;
    localparam logic [7:0] CHR_LF      = 8'h0A;
    localparam logic [7:0] CHR_ESC     = 8'h1B;

    // Returns {1'b1, value} for '0'-'9', 'A'-'F', 'a'-'f'; {1'b0, 4'h0} otherwise.
    function automatic logic [4:0] hex_nibble(input logic [7:0] b);
        logic [4:0] r;
        r = 5'h00;
        if (b >= 8'h30 && b <= 8'h39) begin
            r = {1'b1, 4'(b - 8'h30)};
        end else if (b >= 8'h41 && b <= 8'h46) begin
            r = {1'b1, 4'(b - 8'h37)};
        end else if (b >= 8'h61 && b <= 8'h66) begin
            r = {1'b1, 4'(b - 8'h57)};
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_flash_cmd_if.sv
// Bundle of the rx byte stream, flash-reader request/response and tx byte stream.
//   slave  : the command block (consumes rx, drives spi request and out stream)
//   master : the surrounding system (uart_rx, flash reader, tx adapter)
interface uart_flash_cmd_if #(
    parameter int unsigned ADDR_W = 24
) ();
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_read;
    logic              spi_read;
    logic [ADDR_W-1:0] spi_addr;
    logic              spi_ready;
    logic [7:0]        spi_data;
    logic              out_valid;
    logic [7:0]        out_data;
    logic              out_ready;
    logic              busy;
    logic              err;

    modport slave (
        input  rx_valid, rx_data, spi_ready, spi_data, out_ready,
        output rx_read, spi_read, spi_addr, out_valid, out_data, busy, err
    );

    modport master (
        output rx_valid, rx_data, spi_ready, spi_data, out_ready,
        input  rx_read, spi_read, spi_addr, out_valid, out_data, busy, err
    );
endinterface

// File: rtl/uart_flash_cmd.sv
// Parses "R<addr hex><len hex><CR|LF>" from the rx byte stream, issues len
// sequential single-byte flash reads and forwards each byte on the out stream.
//   clk, rst : clock, synchronous active-high reset
//   bus      : rx stream in, flash read request/response, out stream, busy/err
module uart_flash_cmd
    import flash_cmd_pkg::*;
#(
    parameter int unsigned ADDR_W = 24,
    parameter int unsigned LEN_W  = 8
) (
    input  logic clk,
    input  logic rst,
    uart_flash_cmd_if.slave bus
);

    localparam int unsigned ADDR_DIGITS = ADDR_W / 4;
    localparam int unsigned LEN_DIGITS  = LEN_W / 4;
    localparam int unsigned MAX_DIGITS  = (ADDR_DIGITS > LEN_DIGITS) ? ADDR_DIGITS : LEN_DIGITS;
    localparam int unsigned CNT_W       = $clog2(MAX_DIGITS + 1);
    localparam logic [LEN_W:0] FULL_LEN = {1'b1, {LEN_W{1'b0}}};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  dcnt_q, dcnt_d;
    logic [LEN_W:0]    remain_q, remain_d;
    logic              abort_q, abort_d;
    logic              spi_read_q, spi_read_d;
    logic [ADDR_W-1:0] spi_addr_q, spi_addr_d;
    logic              out_valid_q, out_valid_d;
    logic [7:0]        out_data_q, out_data_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic [4:0]        hex;
    logic              esc_now;
    logic              abort_now;

    assign hex     = hex_nibble(bus.rx_data);
    assign esc_now = bus.rx_valid && (bus.rx_data == CHR_ESC);
    // An ESC arriving in the very cycle of the final transfer still aborts.
    assign abort_now = abort_q || esc_now;

    // Every rx byte is taken the cycle it is offered.
    assign bus.rx_read   = bus.rx_valid & ~rst;
    assign bus.spi_read  = spi_read_q;
    assign bus.spi_addr  = spi_addr_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            dcnt_q      <= '0;
            remain_q    <= '0;
            abort_q     <= 1'b0;
            spi_read_q  <= 1'b0;
            spi_addr_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            dcnt_q      <= dcnt_d;
            remain_q    <= remain_d;
            abort_q     <= abort_d;
            spi_read_q  <= spi_read_d;
            spi_addr_q  <= spi_addr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        dcnt_d      = dcnt_q;
        remain_d    = remain_q;
        abort_d     = abort_q;
        spi_read_d  = 1'b0;
        spi_addr_d  = spi_addr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        busy_d      = busy_q;
        err_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.rx_valid && (bus.rx_data == CMD_READ_UC || bus.rx_data == CMD_READ_LC)) begin
                    state_d = ST_ADDR;
                    dcnt_d  = '0;
                end
            end
            ST_ADDR: begin
                if (bus.rx_valid) begin
                    if (hex[4]) begin
                        addr_d = {addr_q[ADDR_W-5:0], hex[3:0]};
                        if (dcnt_q == CNT_W'(ADDR_DIGITS - 1)) begin
                            state_d = ST_LEN;
                            dcnt_d  = '0;
                        end else begin
                            dcnt_d = dcnt_q + CNT_W'(1);
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_LEN: begin
                if (bus.rx_valid) begin
                    if (hex[4]) begin
                        len_d = {len_q[LEN_W-5:0], hex[3:0]};
                        if (dcnt_q == CNT_W'(LEN_DIGITS - 1)) begin
                            state_d = ST_EOL;
                            dcnt_d  = '0;
                        end else begin
                            dcnt_d = dcnt_q + CNT_W'(1);
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_EOL: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == CHR_CR || bus.rx_data == CHR_LF) begin
                        // Request for the first byte goes out in the RD cycle.
                        state_d    = ST_RD;
                        busy_d     = 1'b1;
                        spi_read_d = 1'b1;
                        spi_addr_d = addr_q;
                        remain_d   = (len_q == '0) ? FULL_LEN : {1'b0, len_q};
                        abort_d    = 1'b0;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RD: begin
                if (esc_now) abort_d = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (esc_now) abort_d = 1'b1;
                if (bus.spi_ready) begin
                    out_data_d  = bus.spi_data;
                    out_valid_d = 1'b1;
                    state_d     = ST_SEND;
                end
            end
            ST_SEND: begin
                if (esc_now) abort_d = 1'b1;
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    remain_d    = remain_q - (LEN_W+1)'(1);
                    spi_addr_d  = spi_addr_q + ADDR_W'(1);
                    if (abort_now) begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        abort_d = 1'b0;
                        state_d = ST_IDLE;
                    end else if (remain_q == (LEN_W+1)'(1)) begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        spi_read_d = 1'b1;
                        state_d    = ST_RD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
